// File: rtl/anc_scheduler_pkg.sv
// Shared types and defaults for the adaptive noise-cancellation sample sequencer.
package anc_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LMS_GO   = 3'd1,
        LMS_WAIT = 3'd2,
        FIR_GO   = 3'd3,
        FIR_WAIT = 3'd4,
        EMIT     = 3'd5
    } anc_sched_state_t;

    localparam int TIMEOUT_CYCLES_DEF = 1024;
    localparam int SAMPLE_W           = 16;
    localparam int CNT_W_DEF          = 8;

endpackage

// File: rtl/anc_scheduler_if.sv
// Handshake bundle between the sequencer and the I2S / LMS / FIR / speaker blocks.
interface anc_scheduler_if
    import anc_pkg::*;
#(
    parameter int DW    = SAMPLE_W,
    parameter int CNT_W = CNT_W_DEF
);
    logic                 sample_pulse_in;
    logic                 adapt_en_in;
    logic                 mute_in;
    logic                 lms_done_in;
    logic                 fir_done_in;
    logic signed [DW-1:0] fir_result_in;
    logic                 lms_start_out;
    logic                 fir_start_out;
    logic signed [DW-1:0] sample_out;
    logic                 sample_valid_out;
    logic                 busy_out;
    logic [CNT_W-1:0]     drop_count_out;
    logic [CNT_W-1:0]     timeout_count_out;
    logic                 error_flag_out;

    modport master (
        output sample_pulse_in, adapt_en_in, mute_in, lms_done_in, fir_done_in, fir_result_in,
        input  lms_start_out, fir_start_out, sample_out, sample_valid_out, busy_out,
        input  drop_count_out, timeout_count_out, error_flag_out
    );

    modport slave (
        input  sample_pulse_in, adapt_en_in, mute_in, lms_done_in, fir_done_in, fir_result_in,
        output lms_start_out, fir_start_out, sample_out, sample_valid_out, busy_out,
        output drop_count_out, timeout_count_out, error_flag_out
    );
endinterface

// File: rtl/anc_scheduler_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-low clear.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             clr_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/anc_scheduler.sv
// Per-sample sequencer: LMS update, FIR, then present the anti-noise sample,
// with one-deep overrun buffering, watchdog abort, adapt-freeze and mute.
module anc_scheduler
    import anc_pkg::*;
#(
    parameter int DW             = SAMPLE_W,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input logic           clk_in,
    input logic           rst_in,
    anc_scheduler_if.slave bus
);
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    anc_sched_state_t     state_q, state_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 req_q, req_d;
    logic                 pending_q, pending_d;
    logic signed [DW-1:0] sample_q, sample_d;
    logic                 err_q, err_d;
    logic                 drop_inc, timeout_inc, idle_free;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            wd_q      <= '0;
            req_q     <= 1'b0;
            pending_q <= 1'b0;
            sample_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            sample_q  <= sample_d;
            err_q     <= err_d;
        end
    end

    // A fresh pulse in a quiet IDLE is registered as the request; the next
    // cycle is the launch decision, so pulses seen then are overruns.
    assign idle_free = (state_q == IDLE) && !req_q && !pending_q;

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        req_d       = 1'b0;
        pending_d   = pending_q;
        sample_d    = sample_q;
        drop_inc    = 1'b0;
        timeout_inc = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_q || pending_q) begin
                    pending_d = 1'b0;
                    state_d   = bus.adapt_en_in ? LMS_GO : FIR_GO;
                end
            end
            LMS_GO: begin
                wd_d    = '0;
                state_d = LMS_WAIT;
            end
            LMS_WAIT: begin
                if (bus.lms_done_in) begin
                    state_d = FIR_GO;
                end else if (wd_q == WD_LAST) begin
                    timeout_inc = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            FIR_GO: begin
                wd_d    = '0;
                state_d = FIR_WAIT;
            end
            FIR_WAIT: begin
                // Mute is applied as the result is registered so the new value
                // and its valid strobe appear together in EMIT.
                if (bus.fir_done_in) begin
                    sample_d = bus.mute_in ? '0 : bus.fir_result_in;
                    state_d  = EMIT;
                end else if (wd_q == WD_LAST) begin
                    timeout_inc = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            EMIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.sample_pulse_in) begin
            if (idle_free) begin
                req_d = 1'b1;
            end else if (!pending_d) begin
                pending_d = 1'b1;
            end else begin
                drop_inc = 1'b1;
            end
        end

        err_d = err_q | drop_inc | timeout_inc;
    end

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk_i  (clk_in),
        .clr_ni (rst_in),
        .inc_i  (drop_inc),
        .count_o(bus.drop_count_out)
    );

    sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
        .clk_i  (clk_in),
        .clr_ni (rst_in),
        .inc_i  (timeout_inc),
        .count_o(bus.timeout_count_out)
    );

    assign bus.lms_start_out    = (state_q == LMS_GO);
    assign bus.fir_start_out    = (state_q == FIR_GO);
    assign bus.sample_valid_out = (state_q == EMIT);
    assign bus.busy_out         = (state_q != IDLE);
    assign bus.sample_out       = sample_q;
    assign bus.error_flag_out   = err_q;
endmodule

// File: tb/tb_anc_scheduler.sv
// Directed bench for anc_scheduler: vector table for single samples plus
// hand-written overrun, saturation, timeout and mid-run reset sequences.
module tb_anc_scheduler;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    always #5 clk_in = ~clk_in;

    anc_scheduler_if #(.DW(16), .CNT_W(8)) bus ();

    anc_scheduler #(.DW(16), .TIMEOUT_CYCLES(1024), .CNT_W(8)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    typedef struct {
        bit                 adapt;
        bit                 mute;
        int                 l_lms;
        int                 l_fir;
        logic signed [15:0] res;
        int                 exp_lms;
        int                 exp_fir_cyc;
        int                 exp_valid_cyc;
        int                 exp_sample;
    } vec_t;

    vec_t vecs[6];

    int n_tests = 0;
    int n_fail  = 0;

    // Observation trackers, indexed by cycle number since the last clear.
    int cyc, n_lms, n_fir, n_valid, first_lms, last_lms, first_fir, first_valid, last_valid;
    logic signed [15:0] valid_sample;

    // LMS/FIR responder models.
    int lms_lat = 1, fir_lat = 1, lms_t = 0, fir_t = 0;
    bit lms_resp_en = 1'b1;
    bit lms_auto, fir_auto, lms_stale, fir_stale;
    logic signed [15:0] fir_val = '0;

    assign bus.lms_done_in   = lms_auto | lms_stale;
    assign bus.fir_done_in   = fir_auto | fir_stale;
    assign bus.fir_result_in = fir_val;

    always @(negedge clk_in) begin
        lms_auto = 1'b0;
        fir_auto = 1'b0;
        if (bus.lms_start_out) begin
            lms_t = lms_lat;
        end else if (lms_t > 0) begin
            lms_t--;
            if (lms_t == 0 && lms_resp_en) lms_auto = 1'b1;
        end
        if (bus.fir_start_out) begin
            fir_t = fir_lat;
        end else if (fir_t > 0) begin
            fir_t--;
            if (fir_t == 0) fir_auto = 1'b1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_obs();
        cyc = 0; n_lms = 0; n_fir = 0; n_valid = 0;
        first_lms = -1; last_lms = -1; first_fir = -1;
        first_valid = -1; last_valid = -1; valid_sample = '0;
    endtask

    // Observe outputs of the current cycle, then drive the pulse for it.
    task automatic step(input bit pls);
        @(negedge clk_in);
        if (bus.lms_start_out) begin
            n_lms++;
            if (first_lms < 0) first_lms = cyc;
            last_lms = cyc;
        end
        if (bus.fir_start_out) begin
            n_fir++;
            if (first_fir < 0) first_fir = cyc;
        end
        if (bus.sample_valid_out) begin
            n_valid++;
            if (first_valid < 0) first_valid = cyc;
            last_valid   = cyc;
            valid_sample = bus.sample_out;
        end
        bus.sample_pulse_in = pls;
        cyc++;
    endtask

    initial begin
        bus.sample_pulse_in = 1'b0;
        bus.adapt_en_in     = 1'b0;
        bus.mute_in         = 1'b0;
        lms_stale = 1'b0;
        fir_stale = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 10, 5, 16'sh1234, 1, 13, 19, 32'sh1234};
        vecs[1] = '{1'b0, 1'b0, 0,  5, -16'sd300, 0, 2,  8,  -300};
        vecs[2] = '{1'b0, 1'b1, 0,  3, 16'sh7FFF, 0, 2,  6,  0};
        vecs[3] = '{1'b0, 1'b0, 0,  3, 16'sh0042, 0, 2,  6,  66};
        vecs[4] = '{1'b1, 1'b0, 1,  1, 16'sh8000, 1, 4,  6,  -32768};
        vecs[5] = '{1'b0, 1'b0, 0,  1, 16'sh7FFF, 0, 2,  4,  32767};

        clear_obs();
        rst_in = 1'b0;
        repeat (3) step(1'b0);
        chk("rst_busy",    int'(bus.busy_out), 0);
        chk("rst_lms",     int'(bus.lms_start_out), 0);
        chk("rst_fir",     int'(bus.fir_start_out), 0);
        chk("rst_valid",   int'(bus.sample_valid_out), 0);
        chk("rst_sample",  int'(bus.sample_out), 0);
        chk("rst_drop",    int'(bus.drop_count_out), 0);
        chk("rst_timeout", int'(bus.timeout_count_out), 0);
        chk("rst_err",     int'(bus.error_flag_out), 0);
        rst_in = 1'b1;
        step(1'b0);

        for (int i = 0; i < 6; i++) begin
            bus.adapt_en_in = vecs[i].adapt;
            bus.mute_in     = vecs[i].mute;
            lms_lat = vecs[i].l_lms;
            fir_lat = vecs[i].l_fir;
            fir_val = vecs[i].res;
            clear_obs();
            step(1'b1);
            repeat (39) step(1'b0);
            chk($sformatf("v%0d_lms_cnt", i),   n_lms, vecs[i].exp_lms);
            chk($sformatf("v%0d_fir_cnt", i),   n_fir, 1);
            chk($sformatf("v%0d_fir_cyc", i),   first_fir, vecs[i].exp_fir_cyc);
            chk($sformatf("v%0d_valid_cnt", i), n_valid, 1);
            chk($sformatf("v%0d_valid_cyc", i), first_valid, vecs[i].exp_valid_cyc);
            chk($sformatf("v%0d_sample", i),    int'(valid_sample), vecs[i].exp_sample);
            chk($sformatf("v%0d_held", i),      int'(bus.sample_out), vecs[i].exp_sample);
            chk($sformatf("v%0d_busy", i),      int'(bus.busy_out), 0);
            if (vecs[i].exp_lms != 0) chk($sformatf("v%0d_lms_cyc", i), first_lms, 2);
        end
        chk("clean_drop",    int'(bus.drop_count_out), 0);
        chk("clean_timeout", int'(bus.timeout_count_out), 0);
        chk("clean_err",     int'(bus.error_flag_out), 0);

        // Three pulses during one long LMS wait.
        bus.adapt_en_in = 1'b1;
        bus.mute_in     = 1'b0;
        lms_lat = 20;
        fir_lat = 2;
        fir_val = 16'sh0101;
        clear_obs();
        for (int c = 0; c < 60; c++) begin
            step(c == 0 || c == 5 || c == 8 || c == 11);
            if (c == 7)  chk("ovr_drop_c7",  int'(bus.drop_count_out), 0);
            if (c == 7)  chk("ovr_err_c7",   int'(bus.error_flag_out), 0);
            if (c == 9)  chk("ovr_drop_c9",  int'(bus.drop_count_out), 1);
            if (c == 9)  chk("ovr_err_c9",   int'(bus.error_flag_out), 1);
            if (c == 12) chk("ovr_drop_c12", int'(bus.drop_count_out), 2);
        end
        chk("ovr_lms_cnt",     n_lms, 2);
        chk("ovr_relaunch",    last_lms, 28);
        chk("ovr_valid_cnt",   n_valid, 2);
        chk("ovr_valid_first", first_valid, 26);
        chk("ovr_valid_last",  last_valid, 52);
        chk("ovr_sample",      int'(valid_sample), 257);
        chk("ovr_busy",        int'(bus.busy_out), 0);

        // Flood of pulses saturates the drop counter.
        lms_lat = 600;
        clear_obs();
        for (int c = 0; c < 1220; c++) begin
            step(c < 300);
            if (c == 100) chk("sat_drop_c100", int'(bus.drop_count_out), 100);
            if (c == 300) chk("sat_drop_c300", int'(bus.drop_count_out), 255);
        end
        chk("sat_drop_end",  int'(bus.drop_count_out), 255);
        chk("sat_valid_cnt", n_valid, 2);
        chk("sat_busy",      int'(bus.busy_out), 0);

        // LMS never completes: watchdog abort.
        lms_resp_en = 1'b0;
        clear_obs();
        for (int c = 0; c < 1040; c++) begin
            step(c == 0);
            lms_stale = (c == 1030);
            if (c == 1026) chk("to_busy_c1026",  int'(bus.busy_out), 1);
            if (c == 1026) chk("to_cnt_c1026",   int'(bus.timeout_count_out), 0);
            if (c == 1027) chk("to_busy_c1027",  int'(bus.busy_out), 0);
            if (c == 1027) chk("to_cnt_c1027",   int'(bus.timeout_count_out), 1);
        end
        lms_stale = 1'b0;
        chk("to_valid_cnt", n_valid, 0);
        chk("to_fir_cnt",   n_fir, 0);
        chk("to_lms_cnt",   n_lms, 1);
        chk("to_sample",    int'(bus.sample_out), 257);
        chk("to_busy_end",  int'(bus.busy_out), 0);
        chk("to_err",       int'(bus.error_flag_out), 1);
        lms_resp_en = 1'b1;

        // One-cycle reset while waiting on the FIR.
        bus.adapt_en_in = 1'b0;
        fir_lat = 5;
        fir_val = 16'sh5555;
        clear_obs();
        for (int c = 0; c < 20; c++) begin
            step(c == 0);
            rst_in = (c == 5) ? 1'b0 : 1'b1;
            if (c == 4) chk("rm_busy_c4",   int'(bus.busy_out), 1);
            if (c == 6) chk("rm_busy_c6",   int'(bus.busy_out), 0);
            if (c == 6) chk("rm_drop",      int'(bus.drop_count_out), 0);
            if (c == 6) chk("rm_timeout",   int'(bus.timeout_count_out), 0);
            if (c == 6) chk("rm_err",       int'(bus.error_flag_out), 0);
            if (c == 6) chk("rm_sample",    int'(bus.sample_out), 0);
            if (c == 8) chk("rm_busy_c8",   int'(bus.busy_out), 0);
        end
        chk("rm_valid_cnt",  n_valid, 0);
        chk("rm_fir_cnt",    n_fir, 1);
        chk("rm_busy_end",   int'(bus.busy_out), 0);
        chk("rm_sample_end", int'(bus.sample_out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
